// File: rtl/rangefinder_pkg.sv
// Shared types and default constants for the rangefinder receive path.
package rangefinder_pkg;
  localparam int SAMPLE_W      = 8;
  localparam int THR_HI_DEF    = 40;
  localparam int THR_LO_DEF    = 24;
  localparam int MIN_WIDTH_DEF = 3;
  localparam int MAX_STOPS_DEF = 5;
  localparam int WINDOW_DEF    = 1000;
  localparam int CNT_W_DEF     = 16;

  typedef enum logic [2:0] {IDLE, START_PK, WAIT_STOP, STOP_PK, DONE} state_t;
endpackage

// File: rtl/peak_tracker.sv
// Tracks max sample, its timestamp and pulse width; shared by start and stop phases.
module peak_tracker import rangefinder_pkg::*; #(
  parameter int CNT_W   = CNT_W_DEF,
  parameter int WIDTH_W = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                seed,
  input  logic                track,
  input  logic [SAMPLE_W-1:0] sample,
  input  logic [CNT_W-1:0]    tcnt,
  output logic [SAMPLE_W-1:0] max,
  output logic [CNT_W-1:0]    peak_t,
  output logic [WIDTH_W-1:0]  width
);
  always_ff @(posedge clk) begin
    if (!reset) begin
      max    <= '0;
      peak_t <= '0;
      width  <= '0;
    end else if (seed) begin
      max    <= sample;
      peak_t <= tcnt;
      width  <= WIDTH_W'(1);
    end else if (track) begin
      if (width != '1) width <= width + WIDTH_W'(1);
      // strict compare: earliest sample of a plateau keeps the peak
      if (sample > max) begin
        max    <= sample;
        peak_t <= tcnt;
      end
    end
  end
endmodule

// File: rtl/pulse_tof_detector.sv
// Start/stop pulse detector with hysteresis; reports stop-minus-start peak time per echo.
module pulse_tof_detector import rangefinder_pkg::*; #(
  parameter int THR_HI    = THR_HI_DEF,
  parameter int THR_LO    = THR_LO_DEF,
  parameter int MIN_WIDTH = MIN_WIDTH_DEF,
  parameter int MAX_STOPS = MAX_STOPS_DEF,
  parameter int WINDOW    = WINDOW_DEF,
  parameter int CNT_W     = CNT_W_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic [SAMPLE_W-1:0] signal,
  output logic                tof_valid,
  output logic [CNT_W-1:0]    tof_data,
  output logic [SAMPLE_W-1:0] tof_amp,
  output logic [2:0]          tof_index,
  output logic                done,
  output logic                timeout,
  output logic [2:0]          stop_count
);
  state_t state, next;
  logic [CNT_W-1:0]    tcnt_q, tnow, start_t, elapsed, pk_t;
  logic [SAMPLE_W-1:0] pk_max;
  logic [7:0]          pk_w;
  logic [2:0]          cnt;
  logic hi, lo_ok, wide;
  logic seed, track, emit, latch_start, finish, expire;

  assign hi      = signal >= SAMPLE_W'(THR_HI);
  assign lo_ok   = signal >= SAMPLE_W'(THR_LO);
  assign wide    = pk_w >= 8'(MIN_WIDTH);
  // timestamp of the sample on the input now; the start sample is always t=0
  assign tnow    = (state == IDLE) ? '0 : tcnt_q;
  assign elapsed = tnow - start_t;

  peak_tracker #(.CNT_W(CNT_W), .WIDTH_W(8)) u_trk (
    .clk(clk), .reset(reset), .seed(seed), .track(track),
    .sample(signal), .tcnt(tnow),
    .max(pk_max), .peak_t(pk_t), .width(pk_w)
  );

  always_comb begin
    next        = state;
    seed        = 1'b0;
    track       = 1'b0;
    emit        = 1'b0;
    latch_start = 1'b0;
    finish      = 1'b0;
    expire      = 1'b0;
    case (state)
      IDLE: if (hi) begin
        seed = 1'b1;
        next = START_PK;
      end
      START_PK: begin
        if (lo_ok) track = 1'b1;
        else if (wide) begin
          latch_start = 1'b1;
          next        = WAIT_STOP;
        end else next = IDLE;
      end
      WAIT_STOP: begin
        // final stop returns here with a full count so done trails its tof_valid by one cycle
        if (cnt == 3'(MAX_STOPS)) begin
          finish = 1'b1;
          next   = DONE;
        end else if (elapsed >= CNT_W'(WINDOW)) begin
          finish = 1'b1;
          expire = 1'b1;
          next   = DONE;
        end else if (hi) begin
          seed = 1'b1;
          next = STOP_PK;
        end
      end
      STOP_PK: begin
        if (lo_ok) track = 1'b1;
        else begin
          emit = wide;
          next = WAIT_STOP;
        end
      end
      DONE:    next = IDLE;
      default: next = IDLE;
    endcase
    if (!enable) begin
      next        = IDLE;
      seed        = 1'b0;
      track       = 1'b0;
      emit        = 1'b0;
      latch_start = 1'b0;
      finish      = 1'b0;
      expire      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      tcnt_q     <= '0;
      start_t    <= '0;
      cnt        <= '0;
      tof_valid  <= 1'b0;
      tof_data   <= '0;
      tof_amp    <= '0;
      tof_index  <= '0;
      done       <= 1'b0;
      timeout    <= 1'b0;
      stop_count <= '0;
    end else begin
      state     <= next;
      tof_valid <= emit;
      done      <= finish;
      timeout   <= expire;
      if (next == IDLE)   tcnt_q <= '0;
      else if (tnow != '1) tcnt_q <= tnow + CNT_W'(1);
      if (latch_start) start_t <= pk_t;
      if (emit) begin
        tof_data  <= pk_t - start_t;
        tof_amp   <= pk_max;
        tof_index <= cnt;
        cnt       <= cnt + 3'd1;
      end else if (next == IDLE) cnt <= '0;
      if (finish) stop_count <= cnt;
    end
  end
endmodule

// File: tb/tb_pulse_tof_detector.sv
// Directed scenarios; expected outputs come from a pulse-segmentation model over the stimulus.
module tb_pulse_tof_detector;
  localparam int HI = 40, LO = 24, MINW = 3, MAXS = 5, WIN = 1000, CW = 16, MAXN = 2600;

  logic clk = 1'b0, reset = 1'b0, enable = 1'b0;
  logic [7:0] signal = '0;
  logic tof_valid, done, timeout;
  logic [CW-1:0] tof_data;
  logic [7:0] tof_amp;
  logic [2:0] tof_index, stop_count;

  pulse_tof_detector dut (
    .clk(clk), .reset(reset), .enable(enable), .signal(signal),
    .tof_valid(tof_valid), .tof_data(tof_data), .tof_amp(tof_amp), .tof_index(tof_index),
    .done(done), .timeout(timeout), .stop_count(stop_count)
  );

  always #5 clk = ~clk;

  int n;
  logic [7:0] s_sig [MAXN];
  bit s_en [MAXN];
  bit s_rst [MAXN];
  bit e_v [MAXN];
  bit e_done [MAXN];
  bit e_to [MAXN];
  int e_data [MAXN];
  int e_amp [MAXN];
  int e_idx [MAXN];
  int e_sc [MAXN];
  int h_data [MAXN];
  int h_amp [MAXN];
  int h_idx [MAXN];
  int h_sc [MAXN];
  int checks = 0, errors = 0;
  bit chk_on = 0;
  int chk_i = 0;
  int amps [5] = '{200, 150, 120, 100, 80};

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic put3(input int v, input bit en, input bit rs);
    s_sig[n] = 8'(v);
    s_en[n]  = en;
    s_rst[n] = rs;
    n++;
  endtask
  task automatic put(input int v); put3(v, 1'b1, 1'b1); endtask
  task automatic noise(input int k); for (int i = 0; i < k; i++) put($urandom_range(0, 15)); endtask
  task automatic quiet(input int k); for (int i = 0; i < k; i++) put(0); endtask
  task automatic start_pulse(); put(50); put(100); put(220); put(100); put(50); put(10); endtask
  task automatic stop_pulse(input int p); put(45); put(p-10); put(p); put(p-10); put(45); put(10); endtask
  task automatic begin_scn(); n = 0; put3(0, 1'b1, 1'b0); put3(0, 1'b1, 1'b0); endtask

  // start at s (peak s+2), five stops peaking 30,60,..150 later
  task automatic train(output int s);
    s = n;
    start_pulse();
    noise(24);
    for (int m = 0; m < 5; m++) begin
      stop_pulse(amps[m]);
      noise(24);
    end
  endtask

  function automatic bit brk(input int j);
    return !s_rst[j] || !s_en[j];
  endfunction
  // first sample after s that ends (or aborts) the pulse starting at s
  function automatic int pend(input int s);
    int k;
    k = s + 1;
    while (k < n && !brk(k) && s_sig[k] >= LO) k++;
    return k;
  endfunction
  function automatic int amax(input int a, input int b);
    int m;
    m = a;
    for (int i = a + 1; i < b; i++) if (s_sig[i] > s_sig[m]) m = i;
    return m;
  endfunction

  task automatic model();
    int j, k, pk, sp, cnt, d, a, x, c;
    bit meas;
    for (int i = 0; i < n; i++) begin
      e_v[i] = 0; e_done[i] = 0; e_to[i] = 0;
      e_data[i] = 0; e_amp[i] = 0; e_idx[i] = 0; e_sc[i] = 0;
    end
    j = 0;
    while (j < n) begin
      if (brk(j) || s_sig[j] < HI) begin j++; continue; end
      k = pend(j);
      if (k >= n) break;
      if (brk(k) || k - j < MINW) begin j = k + 1; continue; end
      pk = amax(j, k);
      cnt = 0;
      j = k + 1;
      meas = 1;
      while (meas && j < n) begin
        if (brk(j)) begin
          meas = 0; j++;
        end else if (cnt == MAXS || j - pk >= WIN) begin
          e_done[j] = 1; e_to[j] = (cnt != MAXS); e_sc[j] = cnt;
          meas = 0; j += 2;
        end else if (s_sig[j] >= HI) begin
          k = pend(j);
          if (k >= n) j = n;
          else if (brk(k)) begin meas = 0; j = k + 1; end
          else begin
            if (k - j >= MINW) begin
              sp = amax(j, k);
              e_v[k] = 1; e_data[k] = sp - pk; e_amp[k] = s_sig[sp]; e_idx[k] = cnt;
              cnt++;
            end
            j = k + 1;
          end
        end else j++;
      end
    end
    d = 0; a = 0; x = 0; c = 0;
    for (int i = 0; i < n; i++) begin
      if (!s_rst[i]) begin d = 0; a = 0; x = 0; c = 0; end
      else begin
        if (e_v[i]) begin d = e_data[i]; a = e_amp[i]; x = e_idx[i]; end
        if (e_done[i]) c = e_sc[i];
      end
      h_data[i] = d; h_amp[i] = a; h_idx[i] = x; h_sc[i] = c;
    end
  endtask

  task automatic tofs(output int q[$]);
    q = {};
    for (int i = 0; i < n; i++) if (e_v[i]) q.push_back(i);
  endtask
  task automatic dones(output int q[$]);
    q = {};
    for (int i = 0; i < n; i++) if (e_done[i]) q.push_back(i);
  endtask

  task automatic run_scn();
    model();
    @(negedge clk);
    for (int i = 0; i < n; i++) begin
      signal = s_sig[i];
      enable = s_en[i];
      reset  = s_rst[i];
      @(posedge clk);
      chk_i  = i;
      chk_on = 1;
      @(negedge clk);
    end
    #1 chk_on = 0;
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      chk($sformatf("tof_valid@%0d", chk_i), int'(tof_valid), int'(e_v[chk_i]));
      chk($sformatf("done@%0d", chk_i), int'(done), int'(e_done[chk_i]));
      chk($sformatf("timeout@%0d", chk_i), int'(timeout), int'(e_to[chk_i]));
      chk($sformatf("tof_data@%0d", chk_i), int'(tof_data), h_data[chk_i]);
      chk($sformatf("tof_amp@%0d", chk_i), int'(tof_amp), h_amp[chk_i]);
      chk($sformatf("tof_index@%0d", chk_i), int'(tof_index), h_idx[chk_i]);
      chk($sformatf("stop_count@%0d", chk_i), int'(stop_count), h_sc[chk_i]);
    end
  end

  initial begin
    int s, s2;
    int q[$];
    int dq[$];

    // 1: full train, five echoes
    begin_scn(); noise(5); train(s); noise(10);
    run_scn();
    tofs(q); dones(dq);
    chk("s1_ntof", q.size(), 5);
    chk("s1_first_tof_at", q[0] - s, 35);
    for (int m = 0; m < 5 && m < q.size(); m++) begin
      chk($sformatf("s1_data%0d", m), e_data[q[m]], 30 * (m + 1));
      chk($sformatf("s1_amp%0d", m), e_amp[q[m]], amps[m]);
      chk($sformatf("s1_idx%0d", m), e_idx[q[m]], m);
    end
    chk("s1_ndone", dq.size(), 1);
    if (dq.size() > 0) begin
      chk("s1_done_at", dq[0] - s, 156);
      chk("s1_sc", e_sc[dq[0]], 5);
      chk("s1_to", int'(e_to[dq[0]]), 0);
    end

    // 2: noise only
    begin_scn(); noise(2000);
    run_scn();
    tofs(q); dones(dq);
    chk("s2_ntof", q.size(), 0);
    chk("s2_ndone", dq.size(), 0);

    // 3: spikes in IDLE and WAIT_STOP, one stop, then enable drop aborts
    begin_scn(); noise(5); put(100); put(0); noise(10);
    s = n; start_pulse(); noise(6); put(100); put(0); noise(6);
    stop_pulse(90); noise(10); put3(5, 1'b0, 1'b1); noise(1100);
    run_scn();
    tofs(q); dones(dq);
    chk("s3_ntof", q.size(), 1);
    if (q.size() > 0) begin
      chk("s3_data", e_data[q[0]], 20);
      chk("s3_amp", e_amp[q[0]], 90);
    end
    chk("s3_ndone", dq.size(), 0);

    // 4: start then silence -> timeout
    begin_scn(); noise(3); s = n; start_pulse(); quiet(1010);
    run_scn();
    tofs(q); dones(dq);
    chk("s4_ntof", q.size(), 0);
    chk("s4_ndone", dq.size(), 1);
    if (dq.size() > 0) begin
      chk("s4_done_at", dq[0] - s, 1002);
      chk("s4_to", int'(e_to[dq[0]]), 1);
      chk("s4_sc", e_sc[dq[0]], 0);
    end

    // 5: plateau start
    begin_scn(); noise(3); s = n;
    put(60); put(120); put(120); put(60); put(0);
    noise(34); stop_pulse(90); noise(1000);
    run_scn();
    tofs(q); dones(dq);
    chk("s5_ntof", q.size(), 1);
    if (q.size() > 0) chk("s5_data", e_data[q[0]], 40);
    chk("s5_ndone", dq.size(), 1);
    if (dq.size() > 0) begin
      chk("s5_done_at", dq[0] - s, 1001);
      chk("s5_to", int'(e_to[dq[0]]), 1);
    end

    // 6: reset after two stops, then a fresh full train
    begin_scn(); noise(5); s = n;
    start_pulse(); noise(24); stop_pulse(200); noise(24); stop_pulse(150); noise(10);
    put3(3, 1'b1, 1'b0); noise(10); train(s2); noise(10);
    run_scn();
    tofs(q); dones(dq);
    chk("s6_ntof", q.size(), 7);
    chk("s6_held_after_rst", h_data[s + 76], 0);
    for (int m = 2; m < 7 && m < q.size(); m++) begin
      chk($sformatf("s6_data%0d", m), e_data[q[m]], 30 * (m - 1));
      chk($sformatf("s6_idx%0d", m), e_idx[q[m]], m - 2);
    end
    chk("s6_ndone", dq.size(), 1);
    if (dq.size() > 0) begin
      chk("s6_done_at", dq[0] - s2, 156);
      chk("s6_sc", e_sc[dq[0]], 5);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
